// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared state encoding, default width and counter sizing helper
// Rev 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_N = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Never returns less than 1 so a counter always has at least one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// div_step : one combinational restoring-division step
// Rev 1.0
// ============================================================================
`default_nettype none

module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   p,
  input  logic         q_msb,
  input  logic [N-1:0] divisor,
  output logic [N:0]   p_next,
  output logic         q_bit
);

  logic [N:0]   w_shifted;
  logic [N+1:0] w_diff;

  // One extra bit on the subtraction exposes the borrow as the sign.
  assign w_shifted = {p[N-1:0], q_msb};
  assign w_diff    = {1'b0, w_shifted} - {2'b00, divisor};
  assign q_bit     = ~w_diff[N+1];
  assign p_next    = q_bit ? w_diff[N:0] : w_shifted;

endmodule

`default_nettype wire

// File: rtl/u_seqdiv16_8.sv
// ============================================================================
// u_seqdiv16_8 : sequential unsigned restoring divider, 2N / N -> N quotient, N remainder
// Rev 1.0
// ============================================================================
`default_nettype none

module u_seqdiv16_8
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           div0,
  output logic           ovf
);

  localparam int                c_cnt_w    = clog2(N);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [2*N-1:0]     r_dividend;
  logic [N-1:0]       r_divisor;
  logic [N:0]         r_p;
  logic [N-1:0]       r_q;
  logic [c_cnt_w-1:0] r_cnt;
  logic [N-1:0]       r_quotient;
  logic [N-1:0]       r_remainder;
  logic               r_div0;
  logic               r_ovf;

  logic               w_accept;
  logic               w_zero_div;
  logic               w_overflow;
  logic               w_last;
  logic [N:0]         w_p_next;
  logic               w_q_bit;

  assign w_accept   = in_valid & in_ready;
  assign w_zero_div = (r_divisor == '0);
  assign w_overflow = (r_dividend[2*N-1:N] >= r_divisor);
  assign w_last     = (r_cnt == c_cnt_last);

  div_step #(
    .N (N)
  ) u_step (
    .p       (r_p),
    .q_msb   (r_q[N-1]),
    .divisor (r_divisor),
    .p_next  (w_p_next),
    .q_bit   (w_q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = CHECK;
      CHECK:   w_state_next = (w_zero_div || w_overflow) ? DONE : ITER;
      ITER:    if (w_last) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Result registers change only in CHECK or on the final step, so a
  // partially iterated quotient never reaches the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_p         <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div0      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dividend <= dividend;
        r_divisor  <= divisor;
      end
      case (r_state)
        CHECK: begin
          if (w_zero_div) begin
            r_div0      <= 1'b1;
            r_ovf       <= 1'b0;
            r_quotient  <= '1;
            r_remainder <= r_dividend[N-1:0];
          end else if (w_overflow) begin
            r_div0      <= 1'b0;
            r_ovf       <= 1'b1;
            r_quotient  <= '1;
            r_remainder <= '0;
          end else begin
            r_div0 <= 1'b0;
            r_ovf  <= 1'b0;
            r_p    <= {1'b0, r_dividend[2*N-1:N]};
            r_q    <= r_dividend[N-1:0];
            r_cnt  <= '0;
          end
        end
        ITER: begin
          r_p   <= w_p_next;
          r_q   <= {r_q[N-2:0], w_q_bit};
          r_cnt <= r_cnt + c_cnt_w'(1);
          if (w_last) begin
            r_quotient  <= {r_q[N-2:0], w_q_bit};
            r_remainder <= w_p_next[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div0      = r_div0;
  assign ovf       = r_ovf;

endmodule

`default_nettype wire
